// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU pattern codes and operand-select encodings.
package cpu_pkg;

    localparam logic [3:0] ALU_PASS_A = 4'd0;
    localparam logic [3:0] ALU_ADD    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_SLL    = 4'd4;
    localparam logic [3:0] ALU_SRL    = 4'd5;
    localparam logic [3:0] ALU_SUB    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_SLT    = 4'd8;
    localparam logic [3:0] ALU_NOR    = 4'd9;
    localparam logic [3:0] ALU_SGT    = 4'd10;

    typedef enum logic [1:0] {
        A_SEL_RS    = 2'd0,
        A_SEL_SHAMT = 2'd1,
        A_SEL_ZERO  = 2'd2,
        A_SEL_RSVD  = 2'd3
    } a_sel_e;

    typedef enum logic {
        B_SEL_RT  = 1'b0,
        B_SEL_IMM = 1'b1
    } b_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Priority forwarding for one source operand: r0 -> 0, then EX/MEM, then WB, then regfile.
module fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic [REG_W-1:0]  addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              exm_we,
    input  logic [REG_W-1:0]  exm_addr,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              wb_we,
    input  logic [REG_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data
);

    // Select the youngest in-flight value for this source register
    always_comb begin
        data = {DATA_W{1'b0}};
        if (addr == {REG_W{1'b0}}) begin
            data = {DATA_W{1'b0}};
        end else if (exm_we && (exm_addr == addr)) begin
            data = exm_data;
        end else if (wb_we && (wb_addr == addr)) begin
            data = wb_data;
        end else begin
            data = rf_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// Execute-entry register: forwarding, operand build and load-use interlock.
// Optional build macro PERF_CNT_EN adds stall_cycles / bubble_count counters.
module ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_rs_addr,
    input  logic [REG_W-1:0]  in_rt_addr,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic              in_use_rs,
    input  logic              in_use_rt,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [4:0]        in_shamt,
    input  logic [1:0]        in_a_sel,
    input  logic              in_b_sel,
    input  logic [3:0]        in_alu_pattern,
    input  logic [REG_W-1:0]  in_rd_addr,
    input  logic              in_reg_we,
    input  logic              in_is_load,
    input  logic              exm_we,
    input  logic [REG_W-1:0]  exm_addr,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              wb_we,
    input  logic [REG_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic [3:0]        alu_pattern,
    output logic [REG_W-1:0]  out_rd_addr,
    output logic              out_reg_we,
    output logic              out_is_load,
`ifdef PERF_CNT_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       bubble_count,
`endif
    output logic [DATA_W-1:0] out_store_data
);

    logic [DATA_W-1:0] rs_fwd_s, rt_fwd_s, a_s, b_s;
    logic              lu_s, advance_s, in_ready_s, accept_s;

    logic              valid_r, reg_we_r, is_load_r;
    logic [DATA_W-1:0] a_r, b_r, store_r;
    logic [3:0]        pattern_r;
    logic [REG_W-1:0]  rd_r;

    fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
        .addr(in_rs_addr), .rf_data(in_rs_data),
        .exm_we(exm_we), .exm_addr(exm_addr), .exm_data(exm_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .data(rs_fwd_s)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
        .addr(in_rt_addr), .rf_data(in_rt_data),
        .exm_we(exm_we), .exm_addr(exm_addr), .exm_data(exm_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .data(rt_fwd_s)
    );

    // Hazard detection and handshake; a load in the output register cannot be forwarded yet
    always_comb begin
        lu_s = valid_r && is_load_r && (rd_r != {REG_W{1'b0}}) &&
               ((in_use_rs && (in_rs_addr == rd_r)) || (in_use_rt && (in_rt_addr == rd_r)));
        advance_s = !valid_r || out_ready;
        if (flush) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = advance_s && !lu_s;
        end
        accept_s = in_valid && in_ready_s && !flush;
    end

    // Operand build; the shift amount travels in A[4:0]
    always_comb begin
        a_s = {DATA_W{1'b0}};
        case (a_sel_e'(in_a_sel))
            A_SEL_RS:    a_s = rs_fwd_s;
            A_SEL_SHAMT: a_s = {{(DATA_W-5){1'b0}}, in_shamt};
            A_SEL_ZERO:  a_s = {DATA_W{1'b0}};
            default:     a_s = {DATA_W{1'b0}};
        endcase
        b_s = {DATA_W{1'b0}};
        case (b_sel_e'(in_b_sel))
            B_SEL_RT:  b_s = rt_fwd_s;
            B_SEL_IMM: b_s = in_imm;
            default:   b_s = {DATA_W{1'b0}};
        endcase
    end

    // Output register: load on accept, bubble on advance without accept, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r   <= 1'b0;
            a_r       <= {DATA_W{1'b0}};
            b_r       <= {DATA_W{1'b0}};
            pattern_r <= 4'd0;
            rd_r      <= {REG_W{1'b0}};
            reg_we_r  <= 1'b0;
            is_load_r <= 1'b0;
            store_r   <= {DATA_W{1'b0}};
        end else if (flush) begin
            valid_r   <= 1'b0;
            reg_we_r  <= 1'b0;
            is_load_r <= 1'b0;
        end else if (advance_s) begin
            if (accept_s) begin
                valid_r   <= 1'b1;
                a_r       <= a_s;
                b_r       <= b_s;
                pattern_r <= in_alu_pattern;
                rd_r      <= in_rd_addr;
                reg_we_r  <= in_reg_we;
                is_load_r <= in_is_load;
                store_r   <= rt_fwd_s;
            end else begin
                valid_r   <= 1'b0;
                reg_we_r  <= 1'b0;
                is_load_r <= 1'b0;
            end
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt_r, bubble_cnt_r;

    // Performance counters, free-running with natural wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r  <= 32'd0;
            bubble_cnt_r <= 32'd0;
        end else begin
            if (in_valid && !in_ready_s && !flush) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (lu_s && advance_s) begin
                bubble_cnt_r <= bubble_cnt_r + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_r;
    assign bubble_count = bubble_cnt_r;
`endif

    assign in_ready       = in_ready_s;
    assign out_valid      = valid_r;
    assign data_a         = a_r;
    assign data_b         = b_r;
    assign alu_pattern    = pattern_r;
    assign out_rd_addr    = rd_r;
    assign out_reg_we     = reg_we_r;
    assign out_is_load    = is_load_r;
    assign out_store_data = store_r;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage (counter checks only with PERF_CNT_EN).
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [4:0]  in_rs_addr, in_rt_addr, in_rd_addr, exm_addr, wb_addr, out_rd_addr, in_shamt;
    logic [31:0] in_rs_data, in_rt_data, in_imm, exm_data, wb_data;
    logic        in_use_rs, in_use_rt, in_b_sel, in_reg_we, in_is_load, exm_we, wb_we;
    logic [1:0]  in_a_sel;
    logic [3:0]  in_alu_pattern, alu_pattern;
    logic        out_valid, out_ready, out_reg_we, out_is_load;
    logic [31:0] data_a, data_b, out_store_data;
`ifdef PERF_CNT_EN
    logic [31:0] stall_cycles, bubble_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
        .in_imm(in_imm), .in_shamt(in_shamt),
        .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
        .in_alu_pattern(in_alu_pattern),
        .in_rd_addr(in_rd_addr), .in_reg_we(in_reg_we), .in_is_load(in_is_load),
        .exm_we(exm_we), .exm_addr(exm_addr), .exm_data(exm_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_a(data_a), .data_b(data_b), .alu_pattern(alu_pattern),
        .out_rd_addr(out_rd_addr), .out_reg_we(out_reg_we), .out_is_load(out_is_load),
`ifdef PERF_CNT_EN
        .stall_cycles(stall_cycles), .bubble_count(bubble_count),
`endif
        .out_store_data(out_store_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_rs_addr = 5'd0; in_rt_addr = 5'd0; in_rs_data = 32'd0; in_rt_data = 32'd0;
        in_use_rs = 1'b0; in_use_rt = 1'b0; in_imm = 32'd0; in_shamt = 5'd0;
        in_a_sel = 2'd0; in_b_sel = 1'b0; in_alu_pattern = 4'd0;
        in_rd_addr = 5'd0; in_reg_we = 1'b0; in_is_load = 1'b0;
        exm_we = 1'b0; exm_addr = 5'd0; exm_data = 32'd0;
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    endtask

    task automatic instr(input logic [4:0] rs, input logic [31:0] rsd,
                         input logic [4:0] rt, input logic [31:0] rtd,
                         input logic [1:0] asel, input logic bsel, input logic [3:0] pat,
                         input logic [4:0] rd, input logic ld);
        in_valid = 1'b1;
        in_rs_addr = rs; in_rs_data = rsd; in_use_rs = 1'b1;
        in_rt_addr = rt; in_rt_data = rtd; in_use_rt = 1'b1;
        in_a_sel = asel; in_b_sel = bsel; in_alu_pattern = pat;
        in_rd_addr = rd; in_reg_we = 1'b1; in_is_load = ld;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".a"}, data_a, 32'd0);
        chk({tag, ".b"}, data_b, 32'd0);
        chk({tag, ".pat"}, {28'd0, alu_pattern}, 32'd0);
        chk({tag, ".rd"}, {27'd0, out_rd_addr}, 32'd0);
        chk({tag, ".we"}, {31'd0, out_reg_we}, 32'd0);
        chk({tag, ".ld"}, {31'd0, out_is_load}, 32'd0);
        chk({tag, ".st"}, out_store_data, 32'd0);
`ifdef PERF_CNT_EN
        chk({tag, ".stall"}, stall_cycles, 32'd0);
        chk({tag, ".bubble"}, bubble_count, 32'd0);
`endif
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk_reset_state("rst");
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

        // ADD r3,r1,r2
        instr(5'd1, 32'd5, 5'd2, 32'd7, 2'd0, 1'b0, 4'd1, 5'd3, 1'b0);
        tick();
        chk("add.a", data_a, 32'd5);
        chk("add.b", data_b, 32'd7);
        chk("add.pat", {28'd0, alu_pattern}, 32'd1);
        chk("add.valid", {31'd0, out_valid}, 32'd1);
        chk("add.rd", {27'd0, out_rd_addr}, 32'd3);
        chk("add.st", out_store_data, 32'd7);

        // EX/MEM beats WB; immediate B; store data still forwarded rt
        instr(5'd1, 32'd1, 5'd1, 32'd1, 2'd0, 1'b1, 4'd1, 5'd3, 1'b0);
        in_imm = 32'h99;
        exm_we = 1'b1; exm_addr = 5'd1; exm_data = 32'h10;
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h20;
        tick();
        chk("fwd_exm.a", data_a, 32'h10);
        chk("fwd_exm.b", data_b, 32'h99);
        chk("fwd_exm.st", out_store_data, 32'h10);

        // WB only
        in_rs_addr = 5'd2; wb_addr = 5'd2;
        tick();
        chk("fwd_wb.a", data_a, 32'h20);

        // r0 always zero even when exm targets it
        in_rs_addr = 5'd0; in_rs_data = 32'h55; exm_addr = 5'd0;
        tick();
        chk("fwd_r0.a", data_a, 32'd0);

        // SLL by shamt 3
        idle();
        instr(5'd0, 32'd0, 5'd2, 32'd1, 2'd1, 1'b0, 4'd4, 5'd6, 1'b0);
        in_shamt = 5'd3;
        tick();
        chk("sll.a", data_a, 32'd3);
        chk("sll.b", data_b, 32'd1);
        chk("sll.pat", {28'd0, alu_pattern}, 32'd4);

        // Variable SRL: amount from forwarded rs
        instr(5'd5, 32'd7, 5'd2, 32'h80, 2'd0, 1'b0, 4'd5, 5'd6, 1'b0);
        exm_we = 1'b1; exm_addr = 5'd5; exm_data = 32'd4;
        tick();
        chk("srl.a", data_a, 32'd4);
        chk("srl.b", data_b, 32'h80);

        // Reserved a_sel yields zero
        idle();
        instr(5'd1, 32'h33, 5'd2, 32'h44, 2'd3, 1'b0, 4'd0, 5'd6, 1'b0);
        tick();
        chk("asel3.a", data_a, 32'd0);

        // Load-use: LW r4 then consumer of r4
        instr(5'd1, 32'h100, 5'd0, 32'd0, 2'd0, 1'b1, 4'd1, 5'd4, 1'b1);
        tick();
        chk("lw.ld", {31'd0, out_is_load}, 32'd1);
        instr(5'd4, 32'h1, 5'd0, 32'd0, 2'd0, 1'b0, 4'd1, 5'd7, 1'b0);
        #1;
        chk("lu.in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("lu.bubble_valid", {31'd0, out_valid}, 32'd0);
        chk("lu.bubble_we", {31'd0, out_reg_we}, 32'd0);
        chk("lu.bubble_ld", {31'd0, out_is_load}, 32'd0);
`ifdef PERF_CNT_EN
        chk("lu.bubble_count", bubble_count, 32'd1);
        chk("lu.stall_cycles", stall_cycles, 32'd1);
`endif
        exm_we = 1'b1; exm_addr = 5'd4; exm_data = 32'hABCD;
        #1;
        chk("lu.in_ready_after", {31'd0, in_ready}, 32'd1);
        tick();
        chk("lu.valid", {31'd0, out_valid}, 32'd1);
        chk("lu.a", data_a, 32'hABCD);

        // Backpressure hold, then flush
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        instr(5'd1, 32'h11, 5'd2, 32'h12, 2'd0, 1'b0, 4'd2, 5'd8, 1'b0);
        tick();
        chk("hold.first", data_a, 32'h11);
        instr(5'd1, 32'h22, 5'd2, 32'h23, 2'd0, 1'b0, 4'd3, 5'd9, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold.in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            chk("hold.a", data_a, 32'h11);
            chk("hold.valid", {31'd0, out_valid}, 32'd1);
            chk("hold.pat", {28'd0, alu_pattern}, 32'd2);
        end
`ifdef PERF_CNT_EN
        chk("hold.stall_cycles", stall_cycles, 32'd3);
`endif
        flush = 1'b1;
        #1;
        chk("flush.in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        flush = 1'b0;
        chk("flush.valid", {31'd0, out_valid}, 32'd0);
`ifdef PERF_CNT_EN
        chk("flush.stall_cycles", stall_cycles, 32'd3);
`endif

        // rst + flush during a load-use stall
        idle();
        instr(5'd1, 32'h1, 5'd0, 32'd0, 2'd0, 1'b0, 4'd1, 5'd6, 1'b1);
        tick();
        instr(5'd6, 32'h1, 5'd0, 32'd0, 2'd0, 1'b0, 4'd1, 5'd7, 1'b0);
        #1;
        chk("rf.lu_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        chk_reset_state("rf");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

Execute-entry pipeline register that builds the two ALU operands and the 4-bit ALU pattern for each decoded instruction. Sits between decode/register-file read and the ALU. Resolves EX/MEM and WB forwarding, places shift amounts into operand A, and interlocks one cycle on load-use hazards. Outputs are registered and drive the ALU inputs directly.

## Interface
- DATA_W, 32, operand width
- REG_W, 5, register address width; register 0 reads as zero
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  discard the current input and the output register contents
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_rs_addr, in_rt_addr  in  REG_W  source register numbers
- in_rs_data, in_rt_data  in  DATA_W  register-file read data
- in_use_rs, in_use_rt  in  1  operand is actually read (hazard qualification)
- in_imm  in  DATA_W  already-extended immediate
- in_shamt  in  5  immediate shift amount
- in_a_sel  in  2  0: rs, 1: {27'b0,shamt}, 2: zero, 3: reserved (zero)
- in_b_sel  in  1  0: rt, 1: imm
- in_alu_pattern  in  4  ALU operation code, passed through
- in_rd_addr  in  REG_W; in_reg_we  in  1; in_is_load  in  1
- exm_we  in  1; exm_addr  in  REG_W; exm_data  in  DATA_W  MEM-stage result (load data included)
- wb_we  in  1; wb_addr  in  REG_W; wb_data  in  DATA_W  write-back result
- out_valid  out  1; out_ready  in  1  downstream accepts
- data_a, data_b  out  DATA_W  ALU operands
- alu_pattern  out  4
- out_rd_addr  out  REG_W; out_reg_we  out  1; out_is_load  out  1
- out_store_data  out  DATA_W  forwarded rt value for stores
- stall_cycles, bubble_count  out  32  present only with PERF_CNT_EN

## Operation
- Forward per source: addr 0 -> 0; else exm_we && exm_addr match -> exm_data; else wb_we && wb_addr match -> wb_data; else regfile data. EX/MEM wins over WB.
- Operand A per in_a_sel; operand B per in_b_sel. Shifts: value in B, amount in A[4:0] (ALU shifts B by A[4:0]).
- out_store_data = forwarded rt regardless of in_b_sel.
- Load-use: lu = out_valid && out_is_load && out_rd_addr != 0 && ((in_use_rs && in_rs_addr == out_rd_addr) || (in_use_rt && in_rt_addr == out_rd_addr)).
- advance = !out_valid || out_ready.
- in_ready = advance && !lu, or 1 when flush.
- On advance: accept (in_valid && in_ready) loads all output fields; else out_valid <= 0 (bubble). An lu cycle with advance inserts a bubble; next cycle the load is in MEM and is forwarded via exm.
- !advance: all outputs hold.
- flush: out_valid <= 0, input dropped, no transfer counted. rst beats flush.
- Bubble output fields: out_reg_we and out_is_load are 0; data fields are don't-care.

## Timing
- Latency 1 cycle: accepted at edge N, visible on outputs after edge N.
- Forwarding and lu are combinational on the inputs in the accept cycle; no combinational path from in_* to out_*.
- Reset values: out_valid 0, data_a 0, data_b 0, alu_pattern 0, out_rd_addr 0, out_reg_we 0, out_is_load 0, out_store_data 0, counters 0.
- Back-to-back acceptance at 1 per cycle when out_ready stays high and no lu.

## Configuration
- PERF_CNT_EN defined:
  - stall_cycles increments on cycles with in_valid && !in_ready && !flush.
  - bubble_count increments on cycles where lu && advance.
  - Both counters wrap at 2^32 and clear on rst.
- PERF_CNT_EN undefined: both counter ports and registers are absent. All other behaviour is identical.

## Structure
- cpu_pkg holds:
  - ALU pattern constants: ALU_PASS_A=0, ALU_ADD=1, ALU_AND=2, ALU_OR=3, ALU_SLL=4, ALU_SRL=5, ALU_SUB=6, ALU_SRA=7, ALU_SLT=8, ALU_NOR=9, ALU_SGT=10.
  - a_sel and b_sel enum typedefs.
- One sub-module, fwd_mux, instantiated twice (rs, rt). It implements the priority forwarding and the zero-register rule.

## Test plan
- ADD r3,r1,r2 with r1=5, r2=7, no hazards -> next cycle data_a=5, data_b=7, alu_pattern=1, out_valid=1.
- exm writes r1=0x10 while wb writes r1=0x20 and the regfile holds 1 -> data_a=0x10. Same case with addr 0 -> data_a=0.
- SLL with shamt=3, rt=r2=0x1 -> data_a=3, data_b=1. Variable SRL uses forwarded rs in data_a.
- LW r4 in the output register, next instruction uses r4 -> in_ready=0 for 1 cycle and a bubble is issued (bubble_count=1). Next cycle, with exm_addr=4 and exm_data=0xABCD, the instruction is accepted with data_a=0xABCD.
- out_ready low for 3 cycles with in_valid high -> outputs hold, in_ready=0, stall_cycles=3. Assert flush mid-hold -> out_valid=0 next cycle.
- rst and flush together during a load-use stall -> all outputs at reset values and counters cleared.
